// File: rtl/dmd_scan_buffer.sv
// Double-buffered 32x16 column store that scans one 16-column half onto a dot-matrix panel.
// The front bank is blanked, latched and shown column by column; it swaps with the back bank only at a frame end.
module dmd_scan_buffer #(
  parameter int COL_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr_en,
  input  logic [4:0]  wr_col,
  input  logic [15:0] wr_data,
  input  logic        buf_clr,
  input  logic        half_sel,
  output logic [3:0]  dmd_seg,
  output logic [15:0] dmd_column,
  output logic        DMD_CLK,
  output logic        DMD_CLR,
  output logic        frame_tick,
  output logic        swap_pending
);

  localparam int CW = $clog2(COL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LATCH = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  logic [15:0] bank [2][32];

  logic        front_sel;
  logic        back_sel;
  logic        half_frame;
  logic        wr_ok;
  logic        wr_last;

  scan_state_t state;
  scan_state_t state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]  idx;
  logic [3:0]  idx_next;
  logic        frame_end;

  logic [3:0]  seg_next;
  logic [15:0] col_next;
  logic        clk_next;
  logic        clr_next;
  logic        tick_next;
  logic [15:0] front_word;

  assign back_sel   = ~front_sel;
  // A write coinciding with a clear is dropped, so it cannot arm a swap either.
  assign wr_ok      = wr_en & ~buf_clr;
  assign wr_last    = wr_ok & (wr_col == 5'd31);
  assign front_word = bank[front_sel][{half_frame, idx_next}];

  // Bank storage: reset clears both, clear zeroes the back bank, writes land in the back bank.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 32; w++) begin
          bank[b][w] <= 16'h0000;
        end
      end
    end else if (buf_clr) begin
      for (int w = 0; w < 32; w++) begin
        bank[back_sel][w] <= 16'h0000;
      end
    end else if (wr_en) begin
      bank[back_sel][wr_col] <= wr_data;
    end
  end

  // Slot counter, column index and scan state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt   <= CNT_ZERO;
      idx   <= 4'd0;
      state <= BLANK;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      state <= state_next;
    end
  end

  // Next slot position and scan-state transitions.
  always_comb begin
    cnt_next   = cnt + CNT_ONE;
    idx_next   = idx;
    frame_end  = 1'b0;
    state_next = state;
    if (cnt == CNT_LAST) begin
      cnt_next  = CNT_ZERO;
      idx_next  = idx + 4'd1;
      frame_end = (idx == 4'd15);
    end else begin
      cnt_next  = cnt + CNT_ONE;
    end
    case (state)
      BLANK:   state_next = (cnt_next == CNT_LATCH) ? LATCH : BLANK;
      LATCH:   state_next = SHOW;
      SHOW:    state_next = (cnt == CNT_LAST) ? BLANK : SHOW;
      default: state_next = BLANK;
    endcase
  end

  // Panel outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    seg_next  = dmd_seg;
    col_next  = dmd_column;
    clk_next  = 1'b0;
    clr_next  = 1'b0;
    tick_next = (cnt_next == CNT_LAST) && (idx_next == 4'd15);
    case (state_next)
      BLANK: begin
        clr_next = 1'b1;
        col_next = 16'h0000;
      end
      LATCH: begin
        seg_next = idx_next;
        col_next = front_word;
        clk_next = 1'b1;
      end
      SHOW: begin
        col_next = dmd_column;
      end
      default: begin
        clr_next = 1'b1;
        col_next = 16'h0000;
      end
    endcase
  end

  // Registered panel outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dmd_seg    <= 4'd0;
      dmd_column <= 16'h0000;
      DMD_CLK    <= 1'b0;
      DMD_CLR    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      dmd_seg    <= seg_next;
      dmd_column <= col_next;
      DMD_CLK    <= clk_next;
      DMD_CLR    <= clr_next;
      frame_tick <= tick_next;
    end
  end

  // Bank swap and half selection only move at a frame end; a column-31 write arriving
  // in that same cycle re-arms the swap for the following frame end.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      half_frame   <= half_sel;
    end else begin
      if (frame_end) begin
        half_frame <= half_sel;
        if (swap_pending) begin
          front_sel <= ~front_sel;
        end else begin
          front_sel <= front_sel;
        end
      end else begin
        half_frame <= half_frame;
        front_sel  <= front_sel;
      end
      if (wr_last) begin
        swap_pending <= 1'b1;
      end else if (frame_end) begin
        swap_pending <= 1'b0;
      end else begin
        swap_pending <= swap_pending;
      end
    end
  end

endmodule

// File: tb/tb_dmd_scan_buffer.sv
// Self-checking bench for dmd_scan_buffer: a slot/frame arithmetic model checked every cycle,
// a table of post-reset scan points, directed swap/clear/reset sequences and random traffic.
module tb_dmd_scan_buffer;
  localparam int C = 8;
  localparam int B = 2;

  logic        CLK;
  logic        RESET;
  logic        wr_en;
  logic [4:0]  wr_col;
  logic [15:0] wr_data;
  logic        buf_clr;
  logic        half_sel;
  logic [3:0]  dmd_seg;
  logic [15:0] dmd_column;
  logic        DMD_CLK;
  logic        DMD_CLR;
  logic        frame_tick;
  logic        swap_pending;

  dmd_scan_buffer #(.COL_CYCLES(C), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .buf_clr(buf_clr), .half_sel(half_sel), .dmd_seg(dmd_seg), .dmd_column(dmd_column),
    .DMD_CLK(DMD_CLK), .DMD_CLR(DMD_CLR), .frame_tick(frame_tick), .swap_pending(swap_pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset plus the two banks and swap bookkeeping.
  logic [15:0] mb [2][32];
  logic        mfront;
  logic        mpend;
  logic        mhalf;
  int          mt;
  logic [3:0]  mseg;
  logic [15:0] mcol;

  typedef struct {
    int          cyc;
    logic [3:0]  seg;
    logic        clk;
    logic        clr;
    logic [15:0] col;
    logic        tick;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0d)", name, act, exp, mt);
    end
  endtask

  task automatic model_edge();
    int ph;
    int ix;
    logic fe;
    logic w31;
    if (RESET) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < 32; w++) mb[b][w] = 16'h0000;
      mfront = 1'b0; mpend = 1'b0; mhalf = half_sel;
      mt = 0; mseg = 4'd0; mcol = 16'h0000;
    end else begin
      ph  = mt % C;
      ix  = (mt / C) % 16;
      fe  = (ph == C - 1) && (ix == 15);
      w31 = wr_en && !buf_clr && (wr_col == 5'd31);
      if (buf_clr) begin
        for (int w = 0; w < 32; w++) mb[!mfront][w] = 16'h0000;
      end else if (wr_en) begin
        mb[!mfront][wr_col] = wr_data;
      end
      if (fe) begin
        if (mpend) mfront = !mfront;
        mhalf = half_sel;
      end
      if (w31) mpend = 1'b1;
      else if (fe) mpend = 1'b0;
      mt++;
      ph = mt % C;
      ix = (mt / C) % 16;
      if (ph == B) begin
        mseg = 4'(ix);
        mcol = mb[mfront][{mhalf, 4'(ix)}];
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    int ix;
    logic [23:0] exp;
    ph  = mt % C;
    ix  = (mt / C) % 16;
    exp = {mseg, (ph < B) ? 16'h0000 : mcol, 1'(ph == B), 1'(ph < B),
           1'((ph == C - 1) && (ix == 15)), mpend};
    chk("cycle_outputs", {8'h00, dmd_seg, dmd_column, DMD_CLK, DMD_CLR, frame_tick, swap_pending},
        {8'h00, exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic wr(input logic [4:0] col, input logic [15:0] data);
    wr_en = 1'b1; wr_col = col; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_to(input int idx, input int ph);
    int n;
    n = 0;
    while (!(((mt % C) == ph) && (((mt / C) % 16) == idx)) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL run_to_timeout actual=%0d required=slot%0d/phase%0d", mt, idx, ph);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    RESET = 1'b1; wr_en = 1'b0; wr_col = 5'd0; wr_data = 16'h0000;
    buf_clr = 1'b0; half_sel = 1'b0;
    mt = 0; mfront = 1'b0; mpend = 1'b0; mhalf = 1'b0; mseg = 4'd0; mcol = 16'h0000;

    vecs[0] = '{0,   4'd0,  1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[1] = '{1,   4'd0,  1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{2,   4'd0,  1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{3,   4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{8,   4'd0,  1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{10,  4'd1,  1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{18,  4'd2,  1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{127, 4'd15, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[8] = '{128, 4'd15, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[9] = '{130, 4'd0,  1'b1, 1'b0, 16'h0000, 1'b0};

    tick();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      while (mt < vecs[i].cyc) tick();
      chk($sformatf("scan_vec%0d", i),
          {11'h000, dmd_seg, DMD_CLK, DMD_CLR, dmd_column, frame_tick},
          {11'h000, vecs[i].seg, vecs[i].clk, vecs[i].clr, vecs[i].col, vecs[i].tick});
    end

    // Back-bank write without column 31 never reaches the panel.
    wr(5'd3, 16'hA5A5);
    seen = 1'b0;
    repeat (300) begin
      tick();
      if (dmd_column == 16'hA5A5) seen = 1'b1;
    end
    chk("no_a5a5_before_swap", 32'(seen), 32'd0);
    chk("no_pending_without_31", 32'(swap_pending), 32'd0);

    // Column-31 write arms the swap; next frame shows the new bank.
    tick();
    wr(5'd31, 16'hFFFF);
    chk("pending_set", 32'(swap_pending), 32'd1);
    run_to(15, C - 1);
    chk("pending_at_frame_end", {30'd0, swap_pending, frame_tick}, {30'd0, 1'b1, 1'b1});
    tick();
    chk("pending_cleared", 32'(swap_pending), 32'd0);
    run_to(3, B);
    chk("slot3_a5a5", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'hA5A5});
    half_sel = 1'b1;
    tick();
    run_to(15, C - 1);
    tick();
    run_to(15, B);
    chk("slot15_upper_ffff", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'hFFFF});
    half_sel = 1'b0;

    // Clear beats a simultaneous write.
    tick();
    wr(5'd6, 16'h5555);
    wr_en = 1'b1; wr_col = 5'd5; wr_data = 16'h1234; buf_clr = 1'b1;
    tick();
    wr_en = 1'b0; buf_clr = 1'b0;
    wr(5'd31, 16'h0001);
    chk("pending_after_clr", 32'(swap_pending), 32'd1);
    run_to(5, B);
    chk("slot5_cleared", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'h0000});
    run_to(6, B);
    chk("slot6_cleared", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'h0000});

    // Column-31 write in the frame-end cycle defers the swap by one frame.
    half_sel = 1'b1;
    run_to(15, C - 1);
    wr(5'd31, 16'h7777);
    chk("pending_deferred", 32'(swap_pending), 32'd1);
    run_to(15, B);
    chk("slot15_not_swapped", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'h0001});
    run_to(15, C - 1);
    tick();
    chk("pending_deferred_cleared", 32'(swap_pending), 32'd0);
    run_to(15, B);
    chk("slot15_swapped", {15'd0, DMD_CLK, dmd_column}, {15'd0, 1'b1, 16'h7777});
    half_sel = 1'b0;

    // Reset during the SHOW of slot 9 with a swap pending.
    run_to(9, B);
    wr(5'd31, 16'h1111);
    tick();
    chk("pending_before_reset", 32'(swap_pending), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("reset_midslot", {10'd0, DMD_CLR, dmd_seg, dmd_column, swap_pending},
        {10'd0, 1'b1, 4'd0, 16'h0000, 1'b0});
    run_to(0, B);
    chk("resume_slot0", {27'd0, DMD_CLK, dmd_seg}, {27'd0, 1'b1, 4'd0});
    run_to(1, B);
    chk("resume_slot1", {27'd0, DMD_CLK, dmd_seg}, {27'd0, 1'b1, 4'd1});

    // Random traffic against the model.
    repeat (3 * 16 * C) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_col  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      wr_data = 16'($urandom);
      buf_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) half_sel = ~half_sel;
      tick();
    end
    wr_en = 1'b0; buf_clr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmd_scan_buffer.md
DMD_SCAN_BUFFER -- requirements
Module: dmd_scan_buffer

Interface
REQ-001 Parameter COL_CYCLES, default 1000, CLK cycles per displayed column slot; COL_CYCLES >= BLANK_CYCLES+2.
REQ-002 Parameter BLANK_CYCLES, default 4, CLK cycles of blanking at the start of each slot; BLANK_CYCLES >= 1.
REQ-003 CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  one-cycle write strobe into the back bank.
REQ-006 wr_col  input  5  column address 0-31 for the write.
REQ-007 wr_data  input  16  column bit pattern; bit n = row n.
REQ-008 buf_clr  input  1  one-cycle strobe; clears the back bank to zero.
REQ-009 half_sel  input  1  0 = display columns 0-15, 1 = columns 16-31.
REQ-010 dmd_seg  output  4  panel column select 0-15.
REQ-011 dmd_column  output  16  row data for the selected column.
REQ-012 DMD_CLK  output  1  one-cycle latch pulse to the panel.
REQ-013 DMD_CLR  output  1  panel blanking, active-high.
REQ-014 frame_tick  output  1  one-cycle pulse at the end of each 16-column frame.
REQ-015 swap_pending  output  1  high from the write of column 31 until the bank swap.

Function
REQ-016 Storage SHALL be two banks of 32 x 16 bits, one front (scanned) and one back (written); front_sel selects the front bank.
REQ-017 wr_en SHALL write wr_data to back[wr_col] at the clock edge; the data SHALL NOT appear on dmd_column before the next swap.
REQ-018 buf_clr SHALL zero all 32 back-bank words in one cycle; buf_clr and wr_en in the same cycle -> clear wins, the write is dropped.
REQ-019 wr_en with wr_col == 31 SHALL set swap_pending on the next cycle; further writes while pending SHALL still go to the back bank.
REQ-020 buf_clr SHALL NOT cancel swap_pending.
REQ-021 Scan FSM states: BLANK, LATCH, SHOW.
  - slot cycle counter 0..COL_CYCLES-1; column index 0..15.
REQ-022 BLANK, counter 0..BLANK_CYCLES-1:
  - DMD_CLR=1, dmd_column=0, DMD_CLK=0, dmd_seg holds its previous value.
REQ-023 LATCH, counter == BLANK_CYCLES:
  - dmd_seg = index.
  - dmd_column = front[{half_frame, index}].
  - DMD_CLK=1 for exactly this cycle; DMD_CLR=0.
REQ-024 SHOW, remaining cycles of the slot:
  - dmd_seg and dmd_column held constant; DMD_CLK=0; DMD_CLR=0.
REQ-025 At counter == COL_CYCLES-1 the counter SHALL wrap to 0, the index SHALL increment, and the FSM SHALL enter BLANK.
REQ-026 Frame end (last cycle of the index-15 slot):
  - index wraps to 0; frame_tick=1 for that cycle.
  - If swap_pending: invert front_sel and clear swap_pending in the same cycle.
REQ-027 If wr_en with wr_col==31 coincides with the frame-end cycle, the swap SHALL be deferred to the next frame end.
REQ-028 half_sel SHALL be sampled into half_frame only at frame end (and at reset); mid-frame changes take effect on the next frame.
REQ-029 dmd_column SHALL be registered; the first visible data is one cycle after the LATCH decision, coincident with DMD_CLK=1.

Reset
REQ-030 RESET SHALL clear the following, on the next clock edge, overriding wr_en and buf_clr:
  - both banks to 0; front_sel=0; swap_pending=0; half_frame=half_sel.
  - counter=0; index=0; state=BLANK.
  - outputs: dmd_seg=0, dmd_column=0, DMD_CLK=0, DMD_CLR=1, frame_tick=0.
REQ-031 RESET asserted mid-slot or mid-swap SHALL abort the slot; scanning restarts at index 0 after RESET deasserts.

Verification (COL_CYCLES=8, BLANK_CYCLES=2)
REQ-032 Release RESET -> DMD_CLK pulses at cycles 2, 10, 18, ...; dmd_seg=0,1,2, ...; dmd_column=0; frame_tick at cycle 127.
REQ-033 Write col 3 = 16'hA5A5, no write to col 31 -> dmd_column never shows A5A5 and swap_pending stays 0.
REQ-034 Write col 3 = 16'hA5A5, then col 31 = 16'hFFFF mid-frame -> swap_pending=1 until frame end; in the next frame, slot 3 shows A5A5 on DMD_CLK; with half_sel=1 in the frame after, slot 15 shows FFFF.
REQ-035 buf_clr and wr_en (col 5 = 16'h1234) in the same cycle, then write col 31 -> after the swap, slot 5 shows 0000.
REQ-036 Write col 31 in the frame-end cycle -> no swap at that frame end; swap at the following frame end.
REQ-037 RESET pulsed during the SHOW of index 9 -> next cycle DMD_CLR=1, dmd_seg=0, dmd_column=0, swap_pending=0; scan resumes at index 0.
